// File: rtl/wall_if.sv
// -----------------------------------------------------------------------------
// wall_if
// Purpose : bundles the wall datapath's control handshake (from the wall
//           control FSM), the player position and the VGA plot bus.
// Signals : start, move          control FSM -> datapath
//           player_x, player_y   player pixel position -> datapath
//           touched              datapath -> control FSM, one-cycle pulse
//           x, y, colour, plot   datapath -> VGA adapter
//           wall_x               current left column of the wall
//           score                only when WALL_SCORE_EN is defined
// Modports: master drives the inputs of the datapath, slave is the datapath.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface wall_if;
    logic       start;
    logic       move;
    logic [7:0] player_x;
    logic [6:0] player_y;
    logic       touched;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic [7:0] wall_x;
`ifdef WALL_SCORE_EN
    logic [7:0] score;
`endif

    modport master (
        output start, move, player_x, player_y,
        input  touched, x, y, colour, plot, wall_x
`ifdef WALL_SCORE_EN
        , input score
`endif
    );

    modport slave (
        input  start, move, player_x, player_y,
        output touched, x, y, colour, plot, wall_x
`ifdef WALL_SCORE_EN
        , output score
`endif
    );
endinterface

// File: rtl/wall_datapath.sv
// -----------------------------------------------------------------------------
// wall_datapath
// Purpose : positions the wall, steps it left once per frame tick and
//           erases/redraws it through the VGA plot bus. Pulses touched when
//           the wall leaves the screen on the left or hits the player.
// Ports   : clk     system clock, rising edge
//           resetn  asynchronous active-low reset
//           bus     wall_if.slave (start/move/player in, touched/VGA/wall_x out)
// Options : WALL_SCORE_EN adds a saturating 8-bit score that counts walls
//           cleared without a collision (bus.score).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module wall_datapath #(
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter int         WALL_W      = 4,
    parameter int         GAP_H       = 32,
    parameter int         FRAME_DIV   = 833334,
    parameter logic [2:0] WALL_COLOUR = 3'b010
) (
    input  logic  clk,
    input  logic  resetn,
    wall_if.slave bus
);

    localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int CW = (WALL_W    > 1) ? $clog2(WALL_W)    : 1;
    localparam int RW = (SCREEN_H  > 1) ? $clog2(SCREEN_H)  : 1;

    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(WALL_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(SCREEN_H - 1);
    localparam logic [6:0]    GAP_LIM    = 7'(SCREEN_H - GAP_H);
    localparam logic [7:0]    X_START    = 8'(SCREEN_W - WALL_W);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_ERASE, S_STEP, S_DRAW, S_CHECK, S_WAIT
    } state_t;

    state_t        r_state, w_next;
    logic [FW-1:0] r_frame;
    logic          r_tick_pend;
    logic [6:0]    r_lfsr;
    logic [6:0]    r_gap_y;
    logic [7:0]    r_wall_x;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [7:0]    r_x_last;
    logic [6:0]    r_y_last;

    logic       w_tick, w_go, w_scan, w_scan_last, w_at_edge;
    logic [7:0] w_scan_x, w_gap_hi, w_wall_r;
    logic [6:0] w_scan_y;
    logic       w_row_in_gap, w_py_in_gap, w_px_hit, w_collide;
    logic       w_plot, w_touched;
    logic [2:0] w_colour;

    assign w_tick      = (r_frame == FRAME_LAST);
    assign w_go        = bus.move && (w_tick || r_tick_pend);
    assign w_scan      = (r_state == S_ERASE) || (r_state == S_DRAW);
    assign w_scan_last = (r_col == COL_LAST) && (r_row == ROW_LAST);
    assign w_at_edge   = (r_wall_x == 8'd0);

    assign w_scan_x = r_wall_x + 8'(r_col);
    assign w_scan_y = 7'(r_row);

    // Gap upper bound is formed one bit wider so a gap near the bottom of a
    // 7-bit row range cannot wrap around.
    assign w_gap_hi     = {1'b0, r_gap_y} + 8'(GAP_H - 1);
    assign w_row_in_gap = (w_scan_y >= r_gap_y) && ({1'b0, w_scan_y} <= w_gap_hi);
    assign w_py_in_gap  = (bus.player_y >= r_gap_y) && ({1'b0, bus.player_y} <= w_gap_hi);
    assign w_wall_r     = r_wall_x + 8'(WALL_W - 1);
    assign w_px_hit     = (bus.player_x >= r_wall_x) && (bus.player_x <= w_wall_r);
    assign w_collide    = w_px_hit && !w_py_in_gap;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_INIT;
            S_INIT:  w_next = S_DRAW;
            S_WAIT:  if (bus.start) w_next = S_INIT;
                     else if (w_go) w_next = S_ERASE;
            S_ERASE: if (w_scan_last) w_next = w_at_edge ? S_IDLE : S_STEP;
            S_STEP:  w_next = S_DRAW;
            S_DRAW:  if (w_scan_last) w_next = S_CHECK;
            S_CHECK: w_next = w_collide ? S_IDLE : S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_plot    = 1'b0;
        w_colour  = 3'b000;
        w_touched = 1'b0;
        case (r_state)
            S_ERASE: begin
                w_plot    = 1'b1;
                w_touched = w_scan_last && w_at_edge;
            end
            S_DRAW: begin
                w_plot   = !w_row_in_gap;
                w_colour = w_row_in_gap ? 3'b000 : WALL_COLOUR;
            end
            S_CHECK: w_touched = w_collide;
            default: ;
        endcase
    end

    assign bus.plot    = w_plot;
    assign bus.colour  = w_colour;
    assign bus.touched = w_touched;
    assign bus.x       = w_plot ? w_scan_x : r_x_last;
    assign bus.y       = w_plot ? w_scan_y : r_y_last;
    assign bus.wall_x  = r_wall_x;

    // Datapath registers: frame timer, tick latch, LFSR, wall position, scan
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_frame     <= '0;
            r_tick_pend <= 1'b0;
            r_lfsr      <= 7'h5A;
            r_gap_y     <= '0;
            r_wall_x    <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_x_last    <= '0;
            r_y_last    <= '0;
        end else begin
            r_frame <= w_tick ? '0 : r_frame + FW'(1);
            r_lfsr  <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};

            // A consumed tick clears the latch; only one tick is ever held
            // while a scan is busy.
            if (r_state == S_WAIT && !bus.start && w_go)
                r_tick_pend <= 1'b0;
            else if (w_tick && w_scan)
                r_tick_pend <= 1'b1;

            if (r_state == S_INIT) begin
                r_wall_x <= X_START;
                r_gap_y  <= (r_lfsr > GAP_LIM) ? (r_lfsr - GAP_LIM) : r_lfsr;
            end else if (r_state == S_STEP && !w_at_edge) begin
                r_wall_x <= r_wall_x - 8'd1;
            end

            // Row-major inside each column; counters rest at zero between scans
            if (w_scan) begin
                if (r_row == ROW_LAST) begin
                    r_row <= '0;
                    r_col <= (r_col == COL_LAST) ? '0 : r_col + CW'(1);
                end else begin
                    r_row <= r_row + RW'(1);
                end
            end else begin
                r_row <= '0;
                r_col <= '0;
            end

            if (w_plot) begin
                r_x_last <= w_scan_x;
                r_y_last <= w_scan_y;
            end
        end
    end

`ifdef WALL_SCORE_EN
    logic [7:0] r_score;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_score <= '0;
        else if (r_state == S_ERASE && w_scan_last && w_at_edge && r_score != 8'hFF)
            r_score <= r_score + 8'd1;
    end

    assign bus.score = r_score;
`endif

endmodule

// File: tb/tb_wall_datapath.sv
`timescale 1ns/1ps

module tb_wall_datapath;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    wall_if bus();

    wall_datapath #(
        .SCREEN_W(16), .SCREEN_H(8), .WALL_W(1), .GAP_H(2),
        .FRAME_DIV(8), .WALL_COLOUR(3'b010)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    // Reference LFSR (x^7+x^6+1, seed 7'h5A), used to predict the gap row.
    logic [6:0] m_lfsr;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) m_lfsr <= 7'h5A;
        else         m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    end

    function automatic logic [6:0] lfsr_next(input logic [6:0] v);
        return {v[5:0], v[6] ^ v[5]};
    endfunction

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_plot, n_erase, n_draw, n_badcol, n_touch;
    logic [7:0] row_mask;
    logic [7:0] last_px;
    logic [7:0] touch_wx;
    int         gap_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_plot = 0; n_erase = 0; n_draw = 0; n_badcol = 0; n_touch = 0;
        row_mask = 8'h00;
    endtask

    // Advance one clock and sample outputs 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.plot === 1'b1) begin
            n_plot++;
            last_px = bus.x;
            if (bus.y < 7'd8) row_mask[bus.y[2:0]] = 1'b1;
            if (bus.colour === 3'b000)      n_erase++;
            else if (bus.colour === 3'b010) n_draw++;
            else                            n_badcol++;
        end
        if (bus.touched === 1'b1) begin
            n_touch++;
            touch_wx = bus.wall_x;
        end
    endtask

    // Pulse start at a moment where the LFSR value seen in INIT is <= 12,
    // so the folded gap row lands at 0..6 and the gap sits fully on screen.
    task automatic do_start();
        int         k;
        logic [6:0] v;
        k = 0;
        while (lfsr_next(m_lfsr) > 7'd12 && k < 300) begin
            step();
            k++;
        end
        chk("lfsr_window", 32'(k < 300), 32'd1);
        v       = lfsr_next(m_lfsr);
        gap_exp = (v > 7'd6) ? int'(v) - 6 : int'(v);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        clear_counts();
    endtask

    initial begin
        int         k, prev, ndec, seq_bad, wx;
        logic [7:0] mask_exp;

        bus.start = 1'b0; bus.move = 1'b0;
        bus.player_x = 8'd100; bus.player_y = 7'd0;
        clear_counts();

        // Reset state
        step();
        chk("rst_plot",    32'(bus.plot),    32'd0);
        chk("rst_touched", 32'(bus.touched), 32'd0);
        chk("rst_wall_x",  32'(bus.wall_x),  32'd0);
        chk("rst_x",       32'(bus.x),       32'd0);
        chk("rst_y",       32'(bus.y),       32'd0);
        chk("rst_colour",  32'(bus.colour),  32'd0);
        resetn = 1'b1;
        repeat (3) step();

        // 1: start -> INIT -> DRAW at column 15 with a 2-row gap
        do_start();
        repeat (12) step();
        mask_exp = 8'hFF & ~(8'd1 << gap_exp) & ~(8'd1 << (gap_exp + 1));
        chk("s1_plot_count", 32'(n_plot),   32'd6);
        chk("s1_row_mask",   32'(row_mask), 32'(mask_exp));
        chk("s1_draw_col",   32'(n_draw),   32'd6);
        chk("s1_bad_colour", 32'(n_badcol), 32'd0);
        chk("s1_last_x",     32'(last_px),  32'd15);
        chk("s1_wall_x",     32'(bus.wall_x), 32'd15);
        chk("s1_no_touch",   32'(n_touch),  32'd0);

        // 2: player far away, wall walks 15 -> 0 then exits on the left
        clear_counts();
        bus.player_x = 8'd100; bus.player_y = 7'd0;
        bus.move = 1'b1;
        prev = 15; ndec = 0; seq_bad = 0; k = 0;
        while (n_touch == 0 && k < 1000) begin
            step();
            if (int'(bus.wall_x) != prev) begin
                if (int'(bus.wall_x) != prev - 1) seq_bad++;
                ndec++;
                prev = int'(bus.wall_x);
            end
            k++;
        end
        chk("s2_touch_seen",  32'(n_touch),  32'd1);
        chk("s2_touch_wx",    32'(touch_wx), 32'd0);
        chk("s2_decrements",  32'(ndec),     32'd15);
        chk("s2_seq_order",   32'(seq_bad),  32'd0);
        chk("s2_erase_px",    32'(n_erase),  32'd128);
        chk("s2_draw_px",     32'(n_draw),   32'd90);
        chk("s2_bad_colour",  32'(n_badcol), 32'd0);
        clear_counts();
        repeat (30) step();
        chk("s2_idle_plot",   32'(n_plot),   32'd0);
        chk("s2_idle_touch",  32'(n_touch),  32'd0);
`ifdef WALL_SCORE_EN
        chk("s2_score", 32'(bus.score), 32'd1);
`endif

        // 3: player at column 10 outside the gap -> collision at wall_x 10
        do_start();
        bus.player_x = 8'd10;
        bus.player_y = (gap_exp >= 2) ? 7'd0 : 7'd7;
        k = 0;
        while (n_touch == 0 && k < 1000) begin
            step();
            k++;
        end
        chk("s3_touch_seen", 32'(n_touch),  32'd1);
        chk("s3_touch_wx",   32'(touch_wx), 32'd10);
        clear_counts();
        repeat (30) step();
        chk("s3_after_plot",  32'(n_plot),     32'd0);
        chk("s3_after_touch", 32'(n_touch),    32'd0);
        chk("s3_wall_held",   32'(bus.wall_x), 32'd10);
`ifdef WALL_SCORE_EN
        chk("s3_score", 32'(bus.score), 32'd1);
`endif

        // 4: player at column 10 inside the gap -> wall passes through
        do_start();
        bus.player_x = 8'd10;
        bus.player_y = 7'(gap_exp);
        k = 0;
        while (bus.wall_x != 8'd9 && k < 1000) begin
            step();
            k++;
        end
        chk("s4_reached_9", 32'(bus.wall_x), 32'd9);
        chk("s4_no_touch",  32'(n_touch),    32'd0);

        // 5: move low in WAIT freezes the wall; start in WAIT reloads it
        bus.move = 1'b0;
        repeat (25) step();
        wx = int'(bus.wall_x);
        chk("s5_settled_x", 32'(wx), 32'd9);
        clear_counts();
        repeat (40) step();
        chk("s5_frozen_plot", 32'(n_plot),     32'd0);
        chk("s5_frozen_x",    32'(bus.wall_x), 32'(wx));
        do_start();
        step();
        chk("s5_reload_x", 32'(bus.wall_x), 32'd15);

        // 6: asynchronous reset in the middle of DRAW
        k = 0;
        while (bus.plot !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk("s6_in_draw", 32'(bus.plot), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("s6_rst_plot",   32'(bus.plot),    32'd0);
        chk("s6_rst_touch",  32'(bus.touched), 32'd0);
        chk("s6_rst_wall_x", 32'(bus.wall_x),  32'd0);
        chk("s6_rst_x",      32'(bus.x),       32'd0);
        chk("s6_rst_y",      32'(bus.y),       32'd0);
        chk("s6_rst_colour", 32'(bus.colour),  32'd0);
`ifdef WALL_SCORE_EN
        chk("s6_rst_score",  32'(bus.score),   32'd0);
`endif
        @(negedge clk);
        resetn = 1'b1;
        clear_counts();
        repeat (20) step();
        chk("s6_idle_plot",  32'(n_plot),  32'd0);
        chk("s6_idle_touch", 32'(n_touch), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
